// File: rtl/mux3_1_a_pkg.sv
// Shared definitions for the one-hot 3:1 mux slice: select encodings.
package mux3_1_a_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_A = 3'b001;
  localparam sel_t SEL_B = 3'b010;
  localparam sel_t SEL_C = 3'b100;

endpackage

// File: rtl/mux3_1_a_onehot3_chk.sv
// One-hot checker for a 3-bit select: valid only for the three legal codes.
module onehot3_chk
  import mux3_1_a_pkg::*;
(
  input  logic [2:0] sl,
  output logic       valid
);

  // Exact match against the legal encodings; 000 and multi-bit codes fail.
  always_comb begin
    valid = (sl == SEL_A) || (sl == SEL_B) || (sl == SEL_C);
  end

endmodule

// File: rtl/mux3_1_a.sv
// 3:1 one-hot mux with registered copy, select-error flag, sticky error
// and saturating error counter.
module mux3_1_a
  import mux3_1_a_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_err,
  output logic             err_stk,
  output logic [CNT_W-1:0] err_cnt
);

  logic sl_valid;

  onehot3_chk u_chk (
    .sl    (sl),
    .valid (sl_valid)
  );

  // Select-error flag straight from the one-hot check.
  always_comb begin
    sel_err = ~sl_valid;
  end

  // Decode-style mux; any illegal code falls through to zero, no priority.
  always_comb begin
    case (sl)
      SEL_A:   out = a;
      SEL_B:   out = b;
      SEL_C:   out = c;
      default: out = '0;
    endcase
  end

  // Registered copy, sticky error and saturating counter; async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      err_stk <= 1'b0;
      err_cnt <= '0;
    end else begin
      out_q   <= out;
      err_stk <= err_stk | sel_err;
      if (sel_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux3_1_a.sv
// Scoreboard bench for mux3_1_a: driver pushes expectations, monitor
// pops and compares at the falling edge.
module tb_mux3_1_a;

  localparam int unsigned W     = 8;
  localparam int unsigned CW    = 8;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [2:0]    sl;
  logic [W-1:0]  a, b, c;
  logic [W-1:0]  out, out_q;
  logic          sel_err, err_stk;
  logic [CW-1:0] err_cnt;

  mux3_1_a #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .sl      (sl),
    .a       (a),
    .b       (b),
    .c       (c),
    .out     (out),
    .out_q   (out_q),
    .sel_err (sel_err),
    .err_stk (err_stk),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] e_out;
    logic         e_err;
    logic [W-1:0] e_q;
    logic         e_stk;
    int           e_cnt;
    int           tag;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference state of the registered outputs as of the most recent edge.
  logic [W-1:0] m_q;
  logic         m_stk;
  int           m_cnt;

  function automatic logic [W-1:0] ref_out(logic [2:0] s, logic [W-1:0] x,
                                           logic [W-1:0] y, logic [W-1:0] z);
    logic [W-1:0] src [3];
    src[0] = x; src[1] = y; src[2] = z;
    if ($countones(s) != 1) return '0;
    for (int i = 0; i < 3; i++) if (s[i]) return src[i];
    return '0;
  endfunction

  // One cycle of stimulus: apply inputs, optionally pulse reset mid-cycle,
  // record what the monitor must see, then advance the model across the edge.
  task automatic step(input logic [2:0] s, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic [W-1:0] vc,
                      input logic r, input int tag);
    exp_t e;
    logic [W-1:0] eo;
    logic         ee;
    sl = s; a = va; b = vb; c = vc;
    if (r) begin
      #1 rst = 1'b1;
      m_q = '0; m_stk = 1'b0; m_cnt = 0;
    end else begin
      rst = 1'b0;
    end
    eo = ref_out(s, va, vb, vc);
    ee = ($countones(s) != 1);
    e.e_out = eo; e.e_err = ee; e.e_q = m_q; e.e_stk = m_stk;
    e.e_cnt = m_cnt; e.tag = tag;
    sb.push_back(e);
    if (!r) begin
      m_q   = eo;
      m_stk = m_stk | ee;
      m_cnt = (m_cnt + int'(ee) > CMAX) ? CMAX : m_cnt + int'(ee);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int tag, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s tag=%0d actual=%0h required=%0h", nm, tag, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is a sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out",     e.tag, int'(out),     int'(e.e_out));
        chk("sel_err", e.tag, int'(sel_err), int'(e.e_err));
        chk("out_q",   e.tag, int'(out_q),   int'(e.e_q));
        chk("err_stk", e.tag, int'(err_stk), int'(e.e_stk));
        chk("err_cnt", e.tag, int'(err_cnt), e.e_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] rs;
    rst = 1'b1; sl = 3'b001; a = '0; b = '0; c = '0;
    m_q = '0; m_stk = 1'b0; m_cnt = 0;
    @(posedge clk); #1;

    // Reset state observed while rst is held.
    step(3'b001, 8'h5A, 8'hA5, 8'h3C, 1'b1, 1);
    step(3'b001, 8'h5A, 8'hA5, 8'h3C, 1'b1, 2);

    // Valid selects stepped with 0/1/0 data.
    step(3'b001, 8'h00, 8'h01, 8'h00, 1'b0, 10);
    step(3'b010, 8'h00, 8'h01, 8'h00, 1'b0, 11);
    step(3'b100, 8'h00, 8'h01, 8'h00, 1'b0, 12);

    // Wide data, b selected; registered copy one edge later.
    step(3'b010, 8'h11, 8'h22, 8'h33, 1'b0, 20);
    step(3'b010, 8'h11, 8'h22, 8'h33, 1'b0, 21);

    // Zero and two-hot selects.
    step(3'b000, 8'h11, 8'h22, 8'h33, 1'b0, 30);
    step(3'b011, 8'h11, 8'h22, 8'h33, 1'b0, 31);
    step(3'b001, 8'h11, 8'h22, 8'h33, 1'b0, 32);

    // c toggled while sl=100 is held.
    step(3'b100, 8'h11, 8'h22, 8'h00, 1'b0, 40);
    step(3'b100, 8'h11, 8'h22, 8'h01, 1'b0, 41);
    step(3'b100, 8'h11, 8'h22, 8'h00, 1'b0, 42);
    step(3'b100, 8'h11, 8'h22, 8'h00, 1'b0, 43);

    // Saturation: 300 invalid cycles, all codes with 0 or 2+ bits.
    for (int i = 0; i < 300; i++) begin
      rs = (i % 4 == 0) ? 3'b000 : (i % 4 == 1) ? 3'b111 :
           (i % 4 == 2) ? 3'b110 : 3'b101;
      step(rs, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 50);
    end
    step(3'b001, 8'h77, 8'h00, 8'h00, 1'b0, 51);

    // Mid-cycle asynchronous reset with err_cnt=5 and out_q nonzero.
    step(3'b010, 8'h00, 8'h00, 8'h00, 1'b1, 60);
    for (int i = 0; i < 5; i++) step(3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 61);
    step(3'b100, 8'h00, 8'h00, 8'hC3, 1'b0, 62);
    step(3'b001, 8'h9E, 8'h00, 8'h00, 1'b0, 63);
    step(3'b010, 8'h00, 8'h4B, 8'h00, 1'b1, 64);
    step(3'b100, 8'h00, 8'h00, 8'h66, 1'b0, 65);
    step(3'b001, 8'h12, 8'h00, 8'h00, 1'b0, 66);

    // Randomized traffic, mostly legal selects, occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rs = 3'b001 << $urandom_range(0, 2);
      else                           rs = 3'($urandom_range(0, 7));
      step(rs, 8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 49) == 0), 100);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 0, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
